// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, a one-entry
// hold register toward decode, and flush/redirect handling.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] npc,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        instr_exc,
   output logic [31:0] pc,
   output logic [31:0] pc4
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic        discard_q;
   logic [31:0] instr_q;
   logic [31:0] instr_pc_q;
   logic        instr_exc_q;
   logic        instr_valid_q;
   logic        aligned;

   assign aligned     = (pc_q[1:0] == 2'b00);
   // Gated by reset so no request leaks out while reset is held.
   assign imem_req    = (state_q == FETCH) && aligned && !reset;
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign pc4         = pc_q + 32'd4;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_exc   = instr_exc_q;
   assign instr_valid = instr_valid_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= FETCH;
         pc_q          <= RESET_PC;
         discard_q     <= 1'b0;
         instr_q       <= 32'h0;
         instr_pc_q    <= 32'h0;
         instr_exc_q   <= 1'b0;
         instr_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            FETCH: begin
               if (aligned) begin
                  if (imem_ready) begin
                     state_q <= WAIT;
                     if (flush) begin
                        discard_q <= 1'b1;
                        pc_q      <= flush_pc;
                     end
                  end else if (flush) begin
                     pc_q <= flush_pc;
                  end
               end else if (flush) begin
                  pc_q <= flush_pc;
               end else begin
                  state_q       <= HOLD;
                  instr_q       <= 32'h0;
                  instr_pc_q    <= pc_q;
                  instr_exc_q   <= 1'b1;
                  instr_valid_q <= 1'b1;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  if (discard_q || flush) begin
                     discard_q <= 1'b0;
                     state_q   <= FETCH;
                     if (flush) pc_q <= flush_pc;
                  end else begin
                     state_q       <= HOLD;
                     instr_q       <= imem_rdata;
                     instr_pc_q    <= pc_q;
                     instr_exc_q   <= 1'b0;
                     instr_valid_q <= 1'b1;
                  end
               end else if (flush) begin
                  discard_q <= 1'b1;
                  pc_q      <= flush_pc;
               end
            end
            HOLD: begin
               if (flush) begin
                  pc_q          <= flush_pc;
                  instr_valid_q <= 1'b0;
                  state_q       <= FETCH;
               end else if (instr_ready) begin
                  pc_q          <= npc;
                  instr_valid_q <= 1'b0;
                  state_q       <= FETCH;
               end
            end
            default: begin
               state_q <= FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, then random traffic
// checked against a program-order scoreboard and a memory model.
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic [31:0] npc;
   logic        flush;
   logic [31:0] flush_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        instr_exc;
   logic [31:0] pc;
   logic [31:0] pc4;

   fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
      .clk        (clk),
      .reset      (reset),
      .npc        (npc),
      .flush      (flush),
      .flush_pc   (flush_pc),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rvalid(imem_rvalid),
      .imem_rdata (imem_rdata),
      .instr      (instr),
      .instr_pc   (instr_pc),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .instr_exc  (instr_exc),
      .pc         (pc),
      .pc4        (pc4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        fl;
      logic [31:0] fpc;
      logic [31:0] npc;
      logic        rdy;
      logic        rv;
      logic [31:0] rdata;
      logic        ird;
      logic        req;
      logic [31:0] addr;
      logic        v;
      logic [31:0] ins;
      logic [31:0] ipc;
      logic        exc;
      logic        ci;
   } vec_t;

   vec_t tbl[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic add(input logic rst, input logic fl, input logic [31:0] fpc,
                      input logic [31:0] np, input logic rdy, input logic rv,
                      input logic [31:0] rd, input logic ird,
                      input logic req, input logic [31:0] addr, input logic v,
                      input logic [31:0] ins, input logic [31:0] ipc,
                      input logic exc, input logic ci);
      vec_t r;
      r.rst = rst; r.fl = fl; r.fpc = fpc; r.npc = np;
      r.rdy = rdy; r.rv = rv; r.rdata = rd; r.ird = ird;
      r.req = req; r.addr = addr; r.v = v; r.ins = ins;
      r.ipc = ipc; r.exc = exc; r.ci = ci;
      tbl.push_back(r);
   endtask

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
   endfunction

   logic [31:0] exp_pc;
   logic [31:0] ei;
   logic [31:0] tmp;
   logic        ee;
   logic        pend;
   logic        delivered;
   logic [31:0] pdata;
   int          cnt;
   int          idle;
   int          accepts;

   initial begin
      reset = 1'b1; flush = 1'b0; flush_pc = '0; npc = '0;
      imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      instr_ready = 1'b0;

      //   rst fl fpc           npc           rdy rv rdata         ird
      //   req addr          v  ins           ipc           exc ci
      add(1,0,0,0,0,0,0,0,            0,32'h3000,0,0,0,0,1);
      add(0,0,0,0,1,0,0,0,            1,32'h3000,0,0,0,0,0);
      add(0,0,0,0,0,1,32'h3C01_1234,0,0,32'h3000,0,0,0,0,0);
      add(0,0,0,0,0,0,0,0,            0,32'h3000,1,32'h3C01_1234,32'h3000,0,1);
      add(0,0,0,0,0,0,0,0,            0,32'h3000,1,32'h3C01_1234,32'h3000,0,1);
      add(0,0,0,0,0,0,0,0,            0,32'h3000,1,32'h3C01_1234,32'h3000,0,1);
      add(0,0,0,32'h3004,0,0,0,1,     0,32'h3000,1,32'h3C01_1234,32'h3000,0,1);
      add(0,0,0,0,1,0,0,0,            1,32'h3004,0,0,0,0,0);
      add(0,1,32'h4180,0,0,0,0,0,     0,32'h3004,0,0,0,0,0);
      add(0,0,0,0,0,1,32'hDEAD_BEEF,0,0,32'h4180,0,0,0,0,0);
      add(0,0,0,0,0,0,0,0,            1,32'h4180,0,0,0,0,0);
      add(0,0,0,0,1,0,0,0,            1,32'h4180,0,0,0,0,0);
      add(0,0,0,0,0,1,32'h1111_2222,0,0,32'h4180,0,0,0,0,0);
      add(0,0,0,32'h3006,0,0,0,1,     0,32'h4180,1,32'h1111_2222,32'h4180,0,1);
      add(0,0,0,0,1,0,0,0,            0,32'h3006,0,0,0,0,0);
      add(0,0,0,0,0,0,0,0,            0,32'h3006,1,0,32'h3006,1,1);
      add(0,0,0,32'h3008,0,0,0,1,     0,32'h3006,1,0,32'h3006,1,1);
      add(0,1,32'h5000,0,1,0,0,0,     1,32'h3008,0,0,0,0,0);
      add(0,0,0,0,0,1,32'hBADB_AD00,0,0,32'h5000,0,0,0,0,0);
      add(0,0,0,0,1,0,0,0,            1,32'h5000,0,0,0,0,0);
      add(0,0,0,0,0,0,0,0,            0,32'h5000,0,0,0,0,0);
      add(1,0,0,0,0,0,0,0,            0,32'h3000,0,0,0,0,1);
      add(0,0,0,0,0,1,32'hCAFE_0000,0,1,32'h3000,0,0,0,0,0);
      add(0,0,0,0,1,0,0,0,            1,32'h3000,0,0,0,0,0);
      add(0,0,0,0,0,1,32'h3C01_1234,0,0,32'h3000,0,0,0,0,0);
      add(0,0,0,0,0,0,0,0,            0,32'h3000,1,32'h3C01_1234,32'h3000,0,1);

      foreach (tbl[i]) begin
         @(negedge clk);
         reset = tbl[i].rst; flush = tbl[i].fl; flush_pc = tbl[i].fpc;
         npc = tbl[i].npc; imem_ready = tbl[i].rdy;
         imem_rvalid = tbl[i].rv; imem_rdata = tbl[i].rdata;
         instr_ready = tbl[i].ird;
         #1;
         chk($sformatf("row%0d_ctl", i),
             {imem_req, imem_addr, instr_valid, pc, pc4},
             {tbl[i].req, tbl[i].addr, tbl[i].v, tbl[i].addr,
              tbl[i].addr + 32'd4});
         if (tbl[i].ci)
            chk($sformatf("row%0d_instr", i),
                {instr, instr_pc, instr_exc},
                {tbl[i].ins, tbl[i].ipc, tbl[i].exc});
      end

      // pc4 wraps modulo 2^32
      @(negedge clk);
      flush = 1'b1; flush_pc = 32'hFFFF_FFFC; instr_ready = 1'b0;
      imem_rvalid = 1'b0; imem_ready = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("pc4_wrap", {imem_req, pc, pc4, instr_valid},
          {1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0});

      // random traffic
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_pc = 32'h0000_3000;
      pend = 1'b0; cnt = 0; pdata = '0; idle = 0; accepts = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (pend && cnt == 0) begin
            imem_rvalid = 1'b1; imem_rdata = pdata;
         end else if (!pend && $urandom_range(7) == 0) begin
            imem_rvalid = 1'b1; imem_rdata = $urandom;
         end else begin
            imem_rvalid = 1'b0; imem_rdata = $urandom;
         end
         imem_ready  = 1'($urandom_range(1));
         instr_ready = 1'($urandom_range(1));
         flush       = ($urandom_range(9) == 0);
         tmp = $urandom;
         flush_pc = {tmp[31:2], ($urandom_range(5) == 0) ? 2'b10 : 2'b00};
         tmp = $urandom;
         npc = {tmp[31:2], ($urandom_range(5) == 0) ? 2'b01 : 2'b00};
         #1;
         if (imem_req)
            chk("rnd_req", {pend, imem_addr, pc4},
                {1'b0, exp_pc, exp_pc + 32'd4});
         if (instr_valid && instr_ready && !flush) begin
            ei = (exp_pc[1:0] != 2'b00) ? 32'h0 : memf(exp_pc);
            ee = (exp_pc[1:0] != 2'b00);
            chk("rnd_accept", {instr_pc, instr, instr_exc},
                {exp_pc, ei, ee});
            exp_pc = npc;
            accepts++;
            idle = 0;
         end
         if (flush) begin
            exp_pc = flush_pc;
            idle = 0;
         end
         idle++;
         if (idle > 60) begin
            chk("rnd_liveness", 128'(idle), 128'(0));
            break;
         end
         delivered = imem_rvalid && pend;
         if (delivered) pend = 1'b0;
         else if (pend) cnt--;
         if (imem_req && imem_ready) begin
            pend = 1'b1;
            cnt = $urandom_range(2);
            pdata = memf(imem_addr);
         end
      end
      chk("rnd_progress", 128'(accepts >= 50), 128'(1));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
